ack_bus_arbiter: RTL and testbench

- Shares the single ack bus between the four NoC endpoints (MEM=0, SHA=1, AES=2, CTRL=3) with round-robin priority.
- The arbiter grants ownership (`owned`). The owner presents one ack request carrying a 2-bit destination ID. The arbiter then delivers a one-cycle ack pulse to that destination and releases the bus.
- Sits beside the memory command port and the accelerators. Its `owned[i]` outputs drive each endpoint's `ack_bus_owned`.

---
 rtl/ack_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ack_bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ack_bus_arbiter.sv
// ack_bus_arbiter: round-robin owner of the shared NoC ack bus.
// Grants one endpoint at a time, forwards its single ack to the addressed
// destination as a one-cycle pulse, then releases the bus with a dead cycle.
// Optional watchdog release: define ACK_ARB_TIMEOUT_EN.
module ack_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] want,
   input  logic [3:0] req,
   input  logic [7:0] req_id,
   output logic [3:0] owned,
   output logic       ack_valid,
   output logic [1:0] ack_src,
   output logic [1:0] ack_dest,
   output logic [3:0] ack_pulse,
   output logic       err_unowned,
   output logic       err_self,
   output logic       timeout
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("ack_bus_arbiter: TIMEOUT_CYCLES must be in 2..255");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] gnt_q, gnt_d;
   logic [3:0] owned_q, owned_d;
   logic       ack_valid_q, ack_valid_d;
   logic [1:0] ack_src_q, ack_src_d;
   logic [1:0] ack_dest_q, ack_dest_d;
   logic [3:0] ack_pulse_q, ack_pulse_d;
   logic       err_unowned_q, err_unowned_d;
   logic       err_self_q, err_self_d;
   logic       timeout_q, timeout_d;

`ifdef ACK_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_q, cnt_d;
`endif

   logic       pick_found;
   logic [1:0] pick_idx;
   logic       req_g;
   logic       want_g;
   logic [1:0] dest_g;

   // round-robin pick: first wanting endpoint after the last grant, wrapping 3->0
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         if (!pick_found && want[ptr_q + 2'(k)]) begin
            pick_found = 1'b1;
            pick_idx   = ptr_q + 2'(k);
         end
      end
   end

   assign req_g  = req[gnt_q];
   assign want_g = want[gnt_q];
   assign dest_g = req_id[{gnt_q, 1'b0} +: 2];

   // next-state and registered-output computation
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      gnt_d         = gnt_q;
      owned_d       = owned_q;
      ack_valid_d   = 1'b0;
      ack_src_d     = 2'd0;
      ack_dest_d    = 2'd0;
      ack_pulse_d   = 4'd0;
      err_self_d    = 1'b0;
      timeout_d     = 1'b0;
      err_unowned_d = |(req & ~owned_q);
`ifdef ACK_ARB_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            owned_d = 4'd0;
            if (pick_found) begin
               gnt_d   = pick_idx;
               owned_d = 4'b0001 << pick_idx;
               state_d = GRANT;
`ifdef ACK_ARB_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         GRANT: begin
            if (req_g) begin
               // a request beats a same-cycle withdrawal or watchdog expiry
               if (dest_g != gnt_q) begin
                  ack_valid_d = 1'b1;
                  ack_src_d   = gnt_q;
                  ack_dest_d  = dest_g;
                  ack_pulse_d = 4'b0001 << dest_g;
               end else begin
                  err_self_d  = 1'b1;
               end
               owned_d = 4'd0;
               ptr_d   = gnt_q;
               state_d = IDLE;
            end else if (!want_g) begin
               owned_d = 4'd0;
               ptr_d   = gnt_q;
               state_d = IDLE;
            end
`ifdef ACK_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LIMIT) begin
               timeout_d = 1'b1;
               owned_d   = 4'd0;
               ptr_d     = gnt_q;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            owned_d = 4'd0;
         end
      endcase
   end

   // state and output registers; reset leaves MEM with first priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= 2'd3;
         gnt_q         <= 2'd0;
         owned_q       <= 4'd0;
         ack_valid_q   <= 1'b0;
         ack_src_q     <= 2'd0;
         ack_dest_q    <= 2'd0;
         ack_pulse_q   <= 4'd0;
         err_unowned_q <= 1'b0;
         err_self_q    <= 1'b0;
         timeout_q     <= 1'b0;
`ifdef ACK_ARB_TIMEOUT_EN
         cnt_q         <= 8'd0;
`endif
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         gnt_q         <= gnt_d;
         owned_q       <= owned_d;
         ack_valid_q   <= ack_valid_d;
         ack_src_q     <= ack_src_d;
         ack_dest_q    <= ack_dest_d;
         ack_pulse_q   <= ack_pulse_d;
         err_unowned_q <= err_unowned_d;
         err_self_q    <= err_self_d;
         timeout_q     <= timeout_d;
`ifdef ACK_ARB_TIMEOUT_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign owned       = owned_q;
   assign ack_valid   = ack_valid_q;
   assign ack_src     = ack_src_q;
   assign ack_dest    = ack_dest_q;
   assign ack_pulse   = ack_pulse_q;
   assign err_unowned = err_unowned_q;
   assign err_self    = err_self_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_ack_bus_arbiter.sv
// Bench for ack_bus_arbiter: directed vector table, hand-written reset and
// watchdog sequences, and randomized traffic against a behavioural model.
module tb_ack_bus_arbiter;

   localparam int TB_TO = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] want = 4'd0;
   logic [3:0] req = 4'd0;
   logic [7:0] req_id = 8'd0;
   logic [3:0] owned;
   logic       ack_valid;
   logic [1:0] ack_src;
   logic [1:0] ack_dest;
   logic [3:0] ack_pulse;
   logic       err_unowned;
   logic       err_self;
   logic       timeout;

   int n_cmp = 0;
   int n_fail = 0;

   ack_bus_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
      .clk(clk), .rst_n(rst_n), .want(want), .req(req), .req_id(req_id),
      .owned(owned), .ack_valid(ack_valid), .ack_src(ack_src),
      .ack_dest(ack_dest), .ack_pulse(ack_pulse), .err_unowned(err_unowned),
      .err_self(err_self), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // behavioural model: owner index (-1 = bus free), last-grant pointer, hold count
   int         m_owner, m_ptr, m_cnt;
   logic [3:0] e_owned, e_pulse;
   logic       e_av, e_es, e_eu, e_to;
   logic [1:0] e_src, e_dst;

   task automatic model_reset();
      m_owner = -1; m_ptr = 3; m_cnt = 0;
      e_owned = 4'd0; e_pulse = 4'd0; e_av = 1'b0; e_es = 1'b0;
      e_eu = 1'b0; e_to = 1'b0; e_src = 2'd0; e_dst = 2'd0;
   endtask

   task automatic model_step(input logic [3:0] w, input logic [3:0] r, input logic [7:0] id);
      int g, d, i;
      e_eu = ((r & ~e_owned) != 4'd0);
      e_av = 1'b0; e_es = 1'b0; e_to = 1'b0; e_pulse = 4'd0; e_src = 2'd0; e_dst = 2'd0;
      if (m_owner < 0) begin
         for (int k = 1; k <= 4; k++) begin
            i = (m_ptr + k) % 4;
            if (m_owner < 0 && w[i]) begin
               m_owner = i;
               m_cnt = 0;
            end
         end
         e_owned = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
      end else begin
         g = m_owner;
         if (r[g]) begin
            d = (int'(id) >> (2 * g)) & 3;
            if (d != g) begin
               e_av = 1'b1; e_src = 2'(g); e_dst = 2'(d); e_pulse = 4'(1 << d);
            end else begin
               e_es = 1'b1;
            end
            m_ptr = g; m_owner = -1; e_owned = 4'd0;
         end else if (!w[g]) begin
            m_ptr = g; m_owner = -1; e_owned = 4'd0;
         end else begin
`ifdef ACK_ARB_TIMEOUT_EN
            if (m_cnt == TB_TO - 1) begin
               e_to = 1'b1; m_ptr = g; m_owner = -1; e_owned = 4'd0;
            end else begin
               m_cnt = m_cnt + 1;
            end
`endif
         end
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("owned", 8'(owned), 8'(e_owned));
      chk("ack_valid", 8'(ack_valid), 8'(e_av));
      chk("ack_pulse", 8'(ack_pulse), 8'(e_pulse));
      chk("err_self", 8'(err_self), 8'(e_es));
      chk("err_unowned", 8'(err_unowned), 8'(e_eu));
      chk("timeout", 8'(timeout), 8'(e_to));
      if (e_av) begin
         chk("ack_src", 8'(ack_src), 8'(e_src));
         chk("ack_dest", 8'(ack_dest), 8'(e_dst));
      end
   endtask

   // called right after a negedge: drive, take one posedge, come back to the negedge
   task automatic tick(input logic [3:0] w, input logic [3:0] r, input logic [7:0] id);
      want = w; req = r; req_id = id;
      @(posedge clk);
      model_step(w, r, id);
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_model();
      want = 4'd0; req = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0] want;
      logic [3:0] req;
      logic [7:0] id;
      logic [3:0] owned;
      logic       av;
      logic [1:0] src;
      logic [1:0] dst;
      logic [3:0] pulse;
      logic       es;
      logic       eu;
   } vec_t;

   vec_t vecs[19];

   initial begin
      //           want   req    id     owned  av    src    dst    pulse  es    eu
      vecs[0]  = '{4'hF, 4'h0, 8'h39, 4'h1, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[1]  = '{4'hF, 4'h1, 8'h39, 4'h0, 1'b1, 2'd0, 2'd1, 4'h2, 1'b0, 1'b0};
      vecs[2]  = '{4'hF, 4'h0, 8'h39, 4'h2, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[3]  = '{4'hF, 4'h2, 8'h39, 4'h0, 1'b1, 2'd1, 2'd2, 4'h4, 1'b0, 1'b0};
      vecs[4]  = '{4'hF, 4'h0, 8'h39, 4'h4, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[5]  = '{4'hF, 4'h4, 8'h39, 4'h0, 1'b1, 2'd2, 2'd3, 4'h8, 1'b0, 1'b0};
      vecs[6]  = '{4'hF, 4'h0, 8'h39, 4'h8, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[7]  = '{4'hF, 4'h8, 8'h39, 4'h0, 1'b1, 2'd3, 2'd0, 4'h1, 1'b0, 1'b0};
      vecs[8]  = '{4'hF, 4'h0, 8'h39, 4'h1, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[9]  = '{4'hF, 4'h1, 8'h39, 4'h0, 1'b1, 2'd0, 2'd1, 4'h2, 1'b0, 1'b0};
      vecs[10] = '{4'h4, 4'h0, 8'h00, 4'h4, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[11] = '{4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[12] = '{4'h6, 4'h0, 8'h00, 4'h2, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[13] = '{4'h6, 4'h2, 8'h04, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 1'b1, 1'b0};
      vecs[14] = '{4'h1, 4'h0, 8'h00, 4'h1, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[15] = '{4'h1, 4'h8, 8'h00, 4'h1, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b1};
      vecs[16] = '{4'h1, 4'h0, 8'h00, 4'h1, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};
      vecs[17] = '{4'h1, 4'h1, 8'h03, 4'h0, 1'b1, 2'd0, 2'd3, 4'h8, 1'b0, 1'b0};
      vecs[18] = '{4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0};

      // power-on reset
      #1 model_reset();
      check_model();
      @(negedge clk);
      rst_n = 1'b1;

      // directed vector table from reset (pointer at 3)
      for (int i = 0; i < 19; i++) begin
         tick(vecs[i].want, vecs[i].req, vecs[i].id);
         chk($sformatf("v%0d_owned", i), 8'(owned), 8'(vecs[i].owned));
         chk($sformatf("v%0d_ack_valid", i), 8'(ack_valid), 8'(vecs[i].av));
         chk($sformatf("v%0d_ack_pulse", i), 8'(ack_pulse), 8'(vecs[i].pulse));
         chk($sformatf("v%0d_err_self", i), 8'(err_self), 8'(vecs[i].es));
         chk($sformatf("v%0d_err_unowned", i), 8'(err_unowned), 8'(vecs[i].eu));
         chk($sformatf("v%0d_timeout", i), 8'(timeout), 8'd0);
         if (vecs[i].av) begin
            chk($sformatf("v%0d_ack_src", i), 8'(ack_src), 8'(vecs[i].src));
            chk($sformatf("v%0d_ack_dest", i), 8'(ack_dest), 8'(vecs[i].dst));
         end
      end

      // reset mid-grant clears ownership without waiting for an edge
      tick(4'h4, 4'h0, 8'h00);
      chk("pre_rst_owned", 8'(owned), 8'h04);
      async_reset();
      chk("rst_owned_immediate", 8'(owned), 8'h00);
      tick(4'h4, 4'h0, 8'h00);
      chk("post_rst_grant", 8'(owned), 8'h04);
      tick(4'h0, 4'h0, 8'h00);
      chk("post_rst_release", 8'(owned), 8'h00);

      // watchdog: owner 0 holds want with no request
      async_reset();
      tick(4'h1, 4'h0, 8'h00);
      chk("wd_grant", 8'(owned), 8'h01);
`ifdef ACK_ARB_TIMEOUT_EN
      for (int k = 1; k <= TB_TO; k++) begin
         tick(4'h1, 4'h0, 8'h00);
         chk($sformatf("wd_owned_%0d", k), 8'(owned), (k < TB_TO) ? 8'h01 : 8'h00);
         chk($sformatf("wd_timeout_%0d", k), 8'(timeout), (k < TB_TO) ? 8'h00 : 8'h01);
      end
      tick(4'h0, 4'h0, 8'h00);
      chk("wd_timeout_pulse_end", 8'(timeout), 8'h00);
`else
      for (int k = 1; k <= 100; k++) begin
         tick(4'h1, 4'h0, 8'h00);
         chk($sformatf("hold_owned_%0d", k), 8'(owned), 8'h01);
         chk($sformatf("hold_timeout_%0d", k), 8'(timeout), 8'h00);
      end
      tick(4'h0, 4'h0, 8'h00);
      chk("hold_release", 8'(owned), 8'h00);
`endif

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] w, r;
         w = want;
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) w[b] = ~w[b];
         r = 4'd0;
         if (m_owner >= 0 && $urandom_range(0, 3) == 0) r[m_owner] = 1'b1;
         if ($urandom_range(0, 15) == 0) r[$urandom_range(0, 3)] = 1'b1;
         if ($urandom_range(0, 499) == 0) begin
            async_reset();
         end else begin
            tick(w, r, 8'($urandom));
            check_model();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
